// File: rtl/cola_dispense_sched.sv
// Dispense scheduler: queues vend pulses and serialises them onto the single
// motor with drop-sensor confirmation, timeout retry, cool-down and fault latch.
module cola_dispense_sched #(
  parameter int PEND_W    = 2,
  parameter int MOTOR_CYC = 4,
  parameter int DROP_TMO  = 8,
  parameter int COOL_CYC  = 2,
  parameter int RETRY_MAX = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              vend_req,
  input  logic              drop_sensor,
  input  logic              stock_empty,
  input  logic              fault_clr,
  output logic              motor_en,
  output logic              dispense_done,
  output logic              fault,
  output logic              busy,
  output logic              req_drop,
  output logic [PEND_W-1:0] pend_cnt
);

  localparam int TMR_MAX = (MOTOR_CYC > DROP_TMO) ?
                           ((MOTOR_CYC > COOL_CYC) ? MOTOR_CYC : COOL_CYC) :
                           ((DROP_TMO  > COOL_CYC) ? DROP_TMO  : COOL_CYC);
  localparam int TMR_W = $clog2(TMR_MAX + 1);
  localparam int RTY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOTOR,
    S_WAIT_DROP,
    S_COOL,
    S_FAULT
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [RTY_W-1:0] retry_cnt, retry_nxt;
  logic [PEND_W-1:0] pend_nxt;
  logic             done_nxt;
  logic             deq, discard, enq;

  // A dequeue frees a slot at the same edge, so a full queue can still accept.
  assign deq     = (state == S_IDLE) && (pend_cnt != '0) && !stock_empty;
  assign discard = vend_req && ((state == S_FAULT) || ((pend_cnt == PEND_MAX) && !deq));
  assign enq     = vend_req && !discard;

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_nxt = state;
    timer_nxt = timer;
    retry_nxt = retry_cnt;
    done_nxt  = 1'b0;
    pend_nxt  = pend_cnt;

    if (enq && !deq)      pend_nxt = pend_cnt + 1'b1;
    else if (deq && !enq) pend_nxt = pend_cnt - 1'b1;

    unique case (state)
      S_IDLE: begin
        if (deq) begin
          state_nxt = S_MOTOR;
          timer_nxt = '0;
          retry_nxt = '0;
        end
      end
      S_MOTOR: begin
        if (timer == TMR_W'(MOTOR_CYC - 1)) begin
          state_nxt = S_WAIT_DROP;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_WAIT_DROP: begin
        if (drop_sensor) begin
          state_nxt = S_COOL;
          timer_nxt = '0;
          done_nxt  = 1'b1;
        end else if (timer == TMR_W'(DROP_TMO - 1)) begin
          timer_nxt = '0;
          if (retry_cnt < RTY_W'(RETRY_MAX)) begin
            state_nxt = S_MOTOR;
            retry_nxt = retry_cnt + 1'b1;
          end else begin
            state_nxt = S_FAULT;
          end
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_COOL: begin
        if (timer == TMR_W'(COOL_CYC - 1)) begin
          state_nxt = S_IDLE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_FAULT: begin
        // Clearing the fault forfeits every queued coin.
        if (fault_clr) begin
          state_nxt = S_IDLE;
          pend_nxt  = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: asynchronous reset with non-blocking assignments for all state; the
  // motor drive decodes from state, so it drops the instant reset asserts.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= S_IDLE;
      timer         <= '0;
      retry_cnt     <= '0;
      pend_cnt      <= '0;
      dispense_done <= 1'b0;
      req_drop      <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      retry_cnt     <= retry_nxt;
      pend_cnt      <= pend_nxt;
      dispense_done <= done_nxt;
      req_drop      <= discard;
    end
  end

  assign motor_en = (state == S_MOTOR);
  assign fault    = (state == S_FAULT);
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_cola_dispense_sched.sv
// Self-checking bench for cola_dispense_sched: directed scenarios plus random
// traffic, all outputs compared every cycle against a countdown-based model.
module tb_cola_dispense_sched;

  localparam int PEND_W    = 2;
  localparam int MOTOR_CYC = 4;
  localparam int DROP_TMO  = 8;
  localparam int COOL_CYC  = 2;
  localparam int RETRY_MAX = 1;
  localparam int PMAX      = (1 << PEND_W) - 1;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              vend_req = 1'b0, drop_sensor = 1'b0, stock_empty = 1'b0, fault_clr = 1'b0;
  logic              motor_en, dispense_done, fault, busy, req_drop;
  logic [PEND_W-1:0] pend_cnt;

  cola_dispense_sched #(
    .PEND_W(PEND_W), .MOTOR_CYC(MOTOR_CYC), .DROP_TMO(DROP_TMO),
    .COOL_CYC(COOL_CYC), .RETRY_MAX(RETRY_MAX)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .vend_req(vend_req),
    .drop_sensor(drop_sensor), .stock_empty(stock_empty), .fault_clr(fault_clr),
    .motor_en(motor_en), .dispense_done(dispense_done), .fault(fault),
    .busy(busy), .req_drop(req_drop), .pend_cnt(pend_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a dispense is a run of countdowns (motor, wait, cool).
  int m_pend, m_motor_left, m_wait_left, m_cool_left, m_tries;
  bit m_active, m_fault, m_done, m_drop;
  int n_motor, n_done, n_rdrop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_motor_left = 0; m_wait_left = 0; m_cool_left = 0; m_tries = 0;
    m_active = 0; m_fault = 0; m_done = 0; m_drop = 0;
  endtask

  task automatic model_step(input bit v, input bit d, input bit s, input bit c);
    bit idle, deq, disc;
    idle = !m_active && !m_fault;
    deq  = idle && (m_pend > 0) && !s;
    disc = v && (m_fault || ((m_pend == PMAX) && !deq));
    m_drop = disc;
    m_done = 0;
    if (m_fault && c) m_pend = 0;
    else m_pend = m_pend + ((v && !disc) ? 1 : 0) - (deq ? 1 : 0);

    if (m_fault) begin
      if (c) m_fault = 0;
    end else if (deq) begin
      m_active = 1; m_motor_left = MOTOR_CYC; m_tries = 0;
    end else if (m_active) begin
      if (m_motor_left > 0) begin
        m_motor_left--;
        if (m_motor_left == 0) m_wait_left = DROP_TMO;
      end else if (m_wait_left > 0) begin
        if (d) begin
          m_done = 1; m_wait_left = 0; m_cool_left = COOL_CYC;
        end else begin
          m_wait_left--;
          if (m_wait_left == 0) begin
            if (m_tries < RETRY_MAX) begin
              m_tries++; m_motor_left = MOTOR_CYC;
            end else begin
              m_active = 0; m_fault = 1;
            end
          end
        end
      end else if (m_cool_left > 0) begin
        m_cool_left--;
        if (m_cool_left == 0) m_active = 0;
      end
    end
  endtask

  task automatic tick(input bit v, input bit d, input bit s, input bit c);
    vend_req = v; drop_sensor = d; stock_empty = s; fault_clr = c;
    @(posedge sys_clk);
    model_step(v, d, s, c);
    #1;
    check("motor_en",      32'(motor_en),      32'(m_motor_left > 0));
    check("dispense_done", 32'(dispense_done), 32'(m_done));
    check("fault",         32'(fault),         32'(m_fault));
    check("busy",          32'(busy),          32'(m_active || m_fault));
    check("req_drop",      32'(req_drop),      32'(m_drop));
    check("pend_cnt",      32'(pend_cnt),      32'(m_pend));
    n_motor += int'(motor_en);
    n_done  += int'(dispense_done);
    n_rdrop += int'(req_drop);
  endtask

  task automatic clear_counts();
    n_motor = 0; n_done = 0; n_rdrop = 0;
  endtask

  task automatic wait_idle(input string tag, input bit d, input int limit);
    int i;
    for (i = 0; i < limit && busy; i++) tick(0, d, 0, 0);
    check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    model_reset();
    clear_counts();
    #23 sys_rst_n = 1'b1;

    // Reset state
    check("rst_motor", 32'(motor_en), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_pend",  32'(pend_cnt), 0);

    // Single vend with a drop three cycles after the motor stops
    clear_counts();
    tick(1, 0, 0, 0);
    check("single_pend1", 32'(pend_cnt), 1);
    tick(0, 0, 0, 0);
    check("single_motor_on", 32'(motor_en), 1);
    check("single_pend0", 32'(pend_cnt), 0);
    for (int i = 0; i < 10 && motor_en; i++) tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    wait_idle("single", 0, 20);
    check("single_motor_cycles", n_motor, MOTOR_CYC);
    check("single_done_count", n_done, 1);

    // Queue saturation while out of stock, then drain
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 1, 0);
      check("sat_pend", 32'(pend_cnt), sat_exp[i]);
    end
    check("sat_req_drop_count", n_rdrop, 2);
    tick(0, 0, 1, 0);
    check("sat_hold_idle", 32'(busy), 0);
    clear_counts();
    for (int i = 0; i < 60; i++) tick(0, 1, 0, 0);
    check("sat_done_count", n_done, 3);
    check("sat_motor_cycles", n_motor, 3 * MOTOR_CYC);
    check("sat_pend_end", 32'(pend_cnt), 0);

    // Retry then success on the second attempt
    clear_counts();
    tick(1, 0, 0, 0);
    for (int i = 0; i < 60 && n_motor < 2 * MOTOR_CYC; i++) tick(0, 0, 0, 0);
    check("retry_second_attempt", n_motor, 2 * MOTOR_CYC);
    check("retry_no_fault", 32'(fault), 0);
    wait_idle("retry", 1, 30);
    check("retry_done_count", n_done, 1);

    // Timeout fault, discard while faulted, then clear
    clear_counts();
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 80 && !fault; i++) tick(0, 0, 0, 0);
    check("tmo_fault", 32'(fault), 1);
    check("tmo_motor_cycles", n_motor, (RETRY_MAX + 1) * MOTOR_CYC);
    check("tmo_done_count", n_done, 0);
    check("tmo_pend_kept", 32'(pend_cnt), 1);
    tick(1, 0, 0, 0);
    check("tmo_req_drop", 32'(req_drop), 1);
    check("tmo_pend_unchanged", 32'(pend_cnt), 1);
    tick(0, 0, 0, 1);
    check("clr_fault", 32'(fault), 0);
    check("clr_busy", 32'(busy), 0);
    check("clr_pend", 32'(pend_cnt), 0);

    // Enqueue and dequeue at the same edge with a full queue
    clear_counts();
    for (int i = 0; i < 3; i++) tick(1, 0, 1, 0);
    check("sim_pend_full", 32'(pend_cnt), 3);
    tick(1, 0, 0, 0);
    check("sim_pend_same", 32'(pend_cnt), 3);
    check("sim_no_req_drop", 32'(req_drop), 0);
    check("sim_started", 32'(motor_en), 1);
    for (int i = 0; i < 80; i++) tick(0, 1, 0, 0);
    check("sim_done_count", n_done, 4);

    // Reset in the middle of a motor run
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    check("mid_motor_running", 32'(motor_en), 1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("mid_rst_motor", 32'(motor_en), 0);
    check("mid_rst_busy",  32'(busy), 0);
    check("mid_rst_fault", 32'(fault), 0);
    check("mid_rst_done",  32'(dispense_done), 0);
    check("mid_rst_drop",  32'(req_drop), 0);
    check("mid_rst_pend",  32'(pend_cnt), 0);
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    clear_counts();
    for (int i = 0; i < 20; i++) tick(0, 1, 0, 0);
    check("post_rst_no_done", n_done, 0);
    check("post_rst_no_motor", n_motor, 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cola_dispense_sched.md
Name: cola_dispense_sched

Overview:
- Scheduler between the no-refund vending FSM and the cola dispensing mechanism.
- Queues one-cycle vend pulses (po_cola) as pending dispenses.
- Serialises them onto the single motor: timed motor drive, drop-sensor handshake with timeout and retry, cool-down, and a latched fault with software clear.

Parameters:
- PEND_W, 2: pending-counter width; queue saturates at 2^PEND_W-1.
- MOTOR_CYC, 4: cycles motor_en is held high per attempt (>=1).
- DROP_TMO, 8: cycles to wait for drop_sensor after motor stop (>=1).
- COOL_CYC, 2: idle cycles after a successful drop before the next dispense (>=1).
- RETRY_MAX, 1: extra motor attempts after a drop timeout before faulting.

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- vend_req  in  1  one-cycle pulse from the vending FSM (its po_cola); one pulse = one cola.
- drop_sensor  in  1  high while a can passes the drop chute; synchronous to sys_clk.
- stock_empty  in  1  level; high = no cans, dispensing must not start.
- fault_clr  in  1  one-cycle pulse; clears the fault state.
- motor_en  out  1  registered dispenser motor drive.
- dispense_done  out  1  registered one-cycle pulse per confirmed drop.
- fault  out  1  registered level; high in FAULT.
- busy  out  1  high in any state except IDLE.
- req_drop  out  1  one-cycle pulse when a vend_req is discarded.
- pend_cnt  out  PEND_W  pending dispenses not yet started.

Behaviour:
- Reset (asynchronous, immediate, including mid-dispense): state IDLE, all outputs 0, pend_cnt 0, timers and retry count 0. The motor stops within the same cycle reset asserts.
- States: IDLE, MOTOR, WAIT_DROP, COOL, FAULT. Outputs decode from registered state: motor_en=(MOTOR), fault=(FAULT), busy=(state!=IDLE).
- Enqueue: vend_req high at an edge increments pend_cnt at that edge.
- Discard: vend_req is discarded and req_drop pulses the next cycle if either:
  - pend_cnt is saturated and no dequeue occurs at the same edge; or
  - state is FAULT.
- Enqueue and dequeue at the same edge leave pend_cnt unchanged and raise no req_drop.
- IDLE -> MOTOR when pend_cnt>0, stock_empty=0, and state is not FAULT. pend_cnt decrements at that edge and the retry count resets to 0. If stock_empty=1, stay in IDLE and keep the count.
- Latency: vend_req at edge k gives pend_cnt=1 after edge k, and motor_en=1 after edge k+1 (pend_cnt back to 0).
- MOTOR: motor_en high for exactly MOTOR_CYC cycles, then WAIT_DROP. drop_sensor is ignored in MOTOR.
- WAIT_DROP: motor_en=0 and a cycle timer runs.
  - drop_sensor high at an edge: go to COOL, dispense_done=1 for the following single cycle.
  - Timer reaches DROP_TMO with no drop: if retry count < RETRY_MAX, increment it and re-enter MOTOR (no pend_cnt change). Otherwise go to FAULT.
- COOL: COOL_CYC cycles, then IDLE. Queued requests resume from IDLE.
- FAULT: latched until fault_clr. fault_clr -> IDLE and pend_cnt cleared to 0 (queued coins are forfeited; no refund). fault_clr in any other state is ignored.
- A drop_sensor level lasting multiple cycles produces only one dispense_done.
- Back-to-back dispenses are spaced by at least MOTOR_CYC + 1 + COOL_CYC + 1 cycles.

Test Plan:
- Single vend, defaults: vend_req at edge 0, drop_sensor pulse 3 cycles after motor_en falls -> motor_en high 4 cycles (after edges 1..4), one dispense_done, busy low after COOL, pend_cnt 0.
- Queue saturation: 5 vend_req pulses on consecutive cycles while stock_empty=1 -> pend_cnt 1,2,3,3,3, two req_drop pulses; release stock_empty -> exactly 3 dispense cycles.
- Retry then success: no drop_sensor for 8 cycles -> motor_en re-asserts for 4 cycles, fault stays 0; drop on second attempt -> one dispense_done.
- Timeout fault: no drop_sensor ever -> 2 motor attempts, then fault=1. vend_req in FAULT -> req_drop, pend_cnt unchanged. fault_clr -> IDLE, pend_cnt=0, fault=0.
- Simultaneous events: pend_cnt=3 in IDLE, vend_req at the dequeue edge -> pend_cnt stays 3, no req_drop.
- Reset mid-operation: assert sys_rst_n low during MOTOR -> motor_en 0 immediately, all outputs 0; after release no spurious dispense.
